// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 raster timing constants shared with the pixel layers
package vga_timing_pkg;
  localparam logic [9:0] H_VIS   = 10'd640;
  localparam logic [9:0] H_FP    = 10'd16;
  localparam logic [9:0] H_SYNC  = 10'd96;
  localparam logic [9:0] H_BP    = 10'd48;
  localparam logic [9:0] H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam logic [9:0] V_VIS   = 10'd480;
  localparam logic [9:0] V_FP    = 10'd10;
  localparam logic [9:0] V_SYNC  = 10'd2;
  localparam logic [9:0] V_BP    = 10'd33;
  localparam logic [9:0] V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  // Sentinels sit above every visible index so no layer band compare can match in blanking
  localparam logic [8:0] ROW_BLANK = 9'd511;
  localparam logic [9:0] COL_BLANK = 10'd1023;

  typedef logic [11:0] rgb444_t;
endpackage

// File: rtl/vga_pipe_delay.sv
// rtl/vga_pipe_delay.sv - fixed-depth shift register with a reset value taken from a port
module vga_pipe_delay #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_rst_val,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);
  localparam int SW = WIDTH * DEPTH;

  if (DEPTH < 1) begin : g_bad_depth
    $error("vga_pipe_delay: DEPTH must be at least 1");
  end

  logic [SW-1:0] r_shift;

  // Newest sample enters at the bottom; the oldest falls off the top
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= {DEPTH{i_rst_val}};
    end else begin
      r_shift <= SW'({r_shift, i_data});
    end
  end

  assign o_data = r_shift[SW-1 -: WIDTH];
endmodule

// File: rtl/vga_scan_ctrl.sv
// rtl/vga_scan_ctrl.sv - raster-scan master: counters, layer addresses, fresh strobe, aligned sync/rgb
module vga_scan_ctrl
  import vga_timing_pkg::*;
#(
  parameter int         PX_LAT = 1,
  parameter logic [9:0] HV     = H_VIS,
  parameter logic [9:0] HF     = H_FP,
  parameter logic [9:0] HS     = H_SYNC,
  parameter logic [9:0] HB     = H_BP,
  parameter logic [9:0] VV     = V_VIS,
  parameter logic [9:0] VF     = V_FP,
  parameter logic [9:0] VS     = V_SYNC,
  parameter logic [9:0] VB     = V_BP
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_px_in,
  input  rgb444_t     i_fg_color,
  input  rgb444_t     i_bg_color,
  output logic [8:0]  o_row_addr,
  output logic [9:0]  o_col_addr,
  output logic        o_fresh,
  output logic        o_hsync,
  output logic        o_vsync,
  output rgb444_t     o_rgb,
  output logic [15:0] o_frame_cnt
);
  localparam logic [9:0] HT = HV + HF + HS + HB;
  localparam logic [9:0] VT = VV + VF + VS + VB;

  if (PX_LAT < 1 || PX_LAT > 4) begin : g_bad_lat
    $error("vga_scan_ctrl: PX_LAT must be 1..4");
  end

  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic [15:0] r_frame_cnt;
  logic [8:0]  r_row_addr;
  logic [9:0]  r_col_addr;
  logic        r_fresh;
  logic        r_hsync;
  logic        r_vsync;
  rgb444_t     r_rgb;

  logic        w_h_last;
  logic        w_v_last;
  logic        w_de;
  logic        w_hs_n;
  logic        w_vs_n;
  logic [2:0]  w_tim_d;

  assign w_h_last = (r_h_cnt == HT - 10'd1);
  assign w_v_last = (r_v_cnt == VT - 10'd1);
  assign w_de     = (r_h_cnt < HV) && (r_v_cnt < VV);
  assign w_hs_n   = !((r_h_cnt >= HV + HF) && (r_h_cnt < HV + HF + HS));
  assign w_vs_n   = !((r_v_cnt >= VV + VF) && (r_v_cnt < VV + VF + VS));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_frame_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      if (w_v_last) begin
        r_v_cnt     <= '0;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else begin
        r_v_cnt <= r_v_cnt + 10'd1;
      end
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  // fresh spans the vertical front porch; layers step on its falling edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row_addr <= '0;
      r_col_addr <= '0;
      r_fresh    <= 1'b0;
    end else begin
      r_col_addr <= (r_h_cnt < HV) ? r_h_cnt : COL_BLANK;
      r_row_addr <= (r_v_cnt < VV) ? r_v_cnt[8:0] : ROW_BLANK;
      r_fresh    <= (r_v_cnt >= VV) && (r_v_cnt < VV + VF);
    end
  end

  // One stage covers the address register, PX_LAT more cover the layer latency
  vga_pipe_delay #(
    .WIDTH (3),
    .DEPTH (PX_LAT + 1)
  ) u_tim_dly (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_rst_val (3'b011),
    .i_data    ({w_de, w_hs_n, w_vs_n}),
    .o_data    (w_tim_d)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rgb   <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else begin
      r_rgb   <= w_tim_d[2] ? (i_px_in ? i_fg_color : i_bg_color) : 12'h000;
      r_hsync <= w_tim_d[1];
      r_vsync <= w_tim_d[0];
    end
  end

  assign o_row_addr  = r_row_addr;
  assign o_col_addr  = r_col_addr;
  assign o_fresh     = r_fresh;
  assign o_hsync     = r_hsync;
  assign o_vsync     = r_vsync;
  assign o_rgb       = r_rgb;
  assign o_frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb/tb_vga_scan_ctrl.sv - self-checking bench: full-size and shrunken-geometry scan controllers
module tb_vga_scan_ctrl;
  typedef struct { int hv, hf, hs, hb, vv, vf, vs, vb, lat; } geom_t;
  typedef struct packed {
    logic [8:0]  row;
    logic [9:0]  col;
    logic        fr;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic [15:0] fc;
  } obs_t;
  typedef struct { int d; int k; int row; int col; bit fr; bit hs; bit vs; int fc; } vec_t;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] fg, bg;
  logic        px  [ND];
  logic [8:0]  row [ND];
  logic [9:0]  col [ND];
  logic        fr  [ND];
  logic        hs  [ND];
  logic        vs  [ND];
  logic [11:0] rgb [ND];
  logic [15:0] fc  [ND];

  geom_t geo [ND];
  vec_t  tab [$];
  logic  hist [ND][5];
  int    k, checks, errors, pmode, seed;
  bit    rand_col;
  int    hs_fall1[ND], hs_fall2[ND], hs_rise1[ND], last_fall[ND];
  int    vs_fall1[ND], vs_fall2[ND], vs_rise1[ND], fc_vs1[ND], fc_vs2[ND];
  int    fr_falls[ND], fr_bad[ND], pix_cnt[ND], pix_off[ND];
  logic  p_hs[ND], p_vs[ND], p_fr[ND];

  always #20 clk = ~clk;

  vga_scan_ctrl u_f1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_px_in(px[0]), .i_fg_color(fg), .i_bg_color(bg),
    .o_row_addr(row[0]), .o_col_addr(col[0]), .o_fresh(fr[0]), .o_hsync(hs[0]),
    .o_vsync(vs[0]), .o_rgb(rgb[0]), .o_frame_cnt(fc[0])
  );

  vga_scan_ctrl #(
    .PX_LAT(1), .HV(10'd20), .HF(10'd4), .HS(10'd6), .HB(10'd5),
    .VV(10'd12), .VF(10'd3), .VS(10'd2), .VB(10'd4)
  ) u_s1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_px_in(px[1]), .i_fg_color(fg), .i_bg_color(bg),
    .o_row_addr(row[1]), .o_col_addr(col[1]), .o_fresh(fr[1]), .o_hsync(hs[1]),
    .o_vsync(vs[1]), .o_rgb(rgb[1]), .o_frame_cnt(fc[1])
  );

  vga_scan_ctrl #(
    .PX_LAT(3), .HV(10'd20), .HF(10'd4), .HS(10'd6), .HB(10'd5),
    .VV(10'd12), .VF(10'd3), .VS(10'd2), .VB(10'd4)
  ) u_s3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_px_in(px[2]), .i_fg_color(fg), .i_bg_color(bg),
    .o_row_addr(row[2]), .o_col_addr(col[2]), .o_fresh(fr[2]), .o_hsync(hs[2]),
    .o_vsync(vs[2]), .o_rgb(rgb[2]), .o_frame_cnt(fc[2])
  );

  // Stand-in pixel layer: mode 0 is a seeded diagonal pattern, mode 1 a single lit pixel
  function automatic logic layer(int mode, int r, int c);
    if (r == 511 || c == 1023) return (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    if (mode == 1) return (r == 7 && c == 5);
    return 1'(((r * 3 + c * 5 + seed) % 7) < 3);
  endfunction

  function automatic obs_t rst_obs();
    obs_t e;
    e.row = '0; e.col = '0; e.fr = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.rgb = '0; e.fc = '0;
    return e;
  endfunction

  // Expected pins after kk clock edges since reset release, from raster position arithmetic
  function automatic obs_t model(geom_t g, int kk, logic [11:0] f, logic [11:0] b);
    int ht, vt, j, h, v;
    obs_t e;
    ht = g.hv + g.hf + g.hs + g.hb;
    vt = g.vv + g.vf + g.vs + g.vb;
    e = rst_obs();
    e.fc = 16'((kk / (ht * vt)) % 65536);
    if (kk > 0) begin
      j = kk - 1; h = j % ht; v = (j / ht) % vt;
      e.col = (h < g.hv) ? 10'(h) : 10'd1023;
      e.row = (v < g.vv) ? 9'(v) : 9'd511;
      e.fr  = (v >= g.vv) && (v < g.vv + g.vf);
    end
    j = kk - g.lat - 2;
    if (j >= 0) begin
      h = j % ht; v = (j / ht) % vt;
      e.hs  = !(h >= g.hv + g.hf && h < g.hv + g.hf + g.hs);
      e.vs  = !(v >= g.vv + g.vf && v < g.vv + g.vf + g.vs);
      e.rgb = (h < g.hv && v < g.vv) ? (layer(pmode, v, h) ? f : b) : 12'h000;
    end
    return e;
  endfunction

  function automatic obs_t grab(int d);
    obs_t a;
    a.row = row[d]; a.col = col[d]; a.fr = fr[d]; a.hs = hs[d];
    a.vs = vs[d]; a.rgb = rgb[d]; a.fc = fc[d];
    return a;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
    end
  endtask

  task automatic restart();
    k = 0;
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 5; i++) hist[d][i] = 1'b0;
      hs_fall1[d] = -1; hs_fall2[d] = -1; hs_rise1[d] = -1; last_fall[d] = 0;
      vs_fall1[d] = -1; vs_fall2[d] = -1; vs_rise1[d] = -1; fc_vs1[d] = 0; fc_vs2[d] = 0;
      fr_falls[d] = 0; fr_bad[d] = 0; pix_cnt[d] = 0; pix_off[d] = -1;
      p_hs[d] = 1'b1; p_vs[d] = 1'b1; p_fr[d] = 1'b0;
    end
  endtask

  task automatic monitor(int d, obs_t a);
    int ht, ft;
    ht = geo[d].hv + geo[d].hf + geo[d].hs + geo[d].hb;
    ft = ht * (geo[d].vv + geo[d].vf + geo[d].vs + geo[d].vb);
    if (p_hs[d] && !a.hs) begin
      if (hs_fall1[d] < 0) hs_fall1[d] = k;
      else if (hs_fall2[d] < 0) hs_fall2[d] = k;
      last_fall[d] = k;
    end
    if (!p_hs[d] && a.hs && hs_fall1[d] >= 0 && hs_rise1[d] < 0) hs_rise1[d] = k;
    if (p_vs[d] && !a.vs) begin
      if (vs_fall1[d] < 0) begin vs_fall1[d] = k; fc_vs1[d] = int'(a.fc); end
      else if (vs_fall2[d] < 0) begin vs_fall2[d] = k; fc_vs2[d] = int'(a.fc); end
    end
    if (!p_vs[d] && a.vs && vs_fall1[d] >= 0 && vs_rise1[d] < 0) vs_rise1[d] = k;
    if (p_fr[d] && !a.fr) begin
      fr_falls[d]++;
      if ((k - 1) % ft != (geo[d].vv + geo[d].vf) * ht) fr_bad[d]++;
    end
    if (pmode == 1 && a.rgb == 12'hFFF) begin
      pix_cnt[d]++;
      pix_off[d] = k - last_fall[d];
    end
    p_hs[d] = a.hs; p_vs[d] = a.vs; p_fr[d] = a.fr;
  endtask

  task automatic tick();
    logic [11:0] f, b;
    obs_t a, e;
    for (int d = 0; d < ND; d++) px[d] = hist[d][geo[d].lat];
    if (rand_col) begin fg = 12'($urandom); bg = 12'($urandom); end
    f = fg; b = bg;
    @(posedge clk);
    #1;
    k++;
    for (int d = 0; d < ND; d++) begin
      a = grab(d);
      e = model(geo[d], k, f, b);
      chk($sformatf("model_dut%0d", d), 64'(a), 64'(e));
      for (int i = 4; i > 0; i--) hist[d][i] = hist[d][i-1];
      hist[d][0] = layer(pmode, int'(a.row), int'(a.col));
      monitor(d, a);
    end
  endtask

  function automatic vec_t mk(int d, int kk, int r, int c, bit f, bit h, bit v, int fcnt);
    vec_t t;
    t.d = d; t.k = kk; t.row = r; t.col = c; t.fr = f; t.hs = h; t.vs = v; t.fc = fcnt;
    return t;
  endfunction

  initial begin
    obs_t a;
    geo[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
    geo[1] = '{20, 4, 6, 5, 12, 3, 2, 4, 1};
    geo[2] = '{20, 4, 6, 5, 12, 3, 2, 4, 3};

    // {dut, edges since release, row, col, fresh, hsync, vsync, frame_cnt}
    tab.push_back(mk(0,    0,   0,    0, 0, 1, 1, 0));
    tab.push_back(mk(0,    1,   0,    0, 0, 1, 1, 0));
    tab.push_back(mk(0,    2,   0,    1, 0, 1, 1, 0));
    tab.push_back(mk(2,  421, 511,    0, 1, 1, 1, 0));
    tab.push_back(mk(2,  525, 511, 1023, 1, 1, 1, 0));
    tab.push_back(mk(2,  526, 511,    0, 0, 1, 1, 0));
    tab.push_back(mk(2,  529, 511,    3, 0, 1, 1, 0));
    tab.push_back(mk(2,  530, 511,    4, 0, 1, 0, 0));
    tab.push_back(mk(2,  600, 511,    4, 0, 1, 1, 0));
    tab.push_back(mk(0,  640,   0,  639, 0, 1, 1, 0));
    tab.push_back(mk(0,  641,   0, 1023, 0, 1, 1, 0));
    tab.push_back(mk(0,  658,   0, 1023, 0, 1, 1, 0));
    tab.push_back(mk(0,  659,   0, 1023, 0, 0, 1, 0));
    tab.push_back(mk(2,  734, 511, 1023, 0, 0, 1, 0));
    tab.push_back(mk(2,  735, 511, 1023, 0, 1, 1, 1));
    tab.push_back(mk(0,  754,   0, 1023, 0, 0, 1, 0));
    tab.push_back(mk(0,  755,   0, 1023, 0, 1, 1, 0));
    tab.push_back(mk(0,  800,   0, 1023, 0, 1, 1, 0));
    tab.push_back(mk(0,  801,   1,    0, 0, 1, 1, 0));
    tab.push_back(mk(0, 1601,   2,    0, 0, 1, 1, 0));

    checks = 0; errors = 0;
    seed = int'($urandom_range(0, 999));
    pmode = 0; rand_col = 1'b1;
    fg = 12'($urandom); bg = 12'($urandom);
    for (int d = 0; d < ND; d++) px[d] = 1'b1;
    rst_n = 1'b0;
    restart();
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) chk($sformatf("reset_hold_dut%0d", d), 64'(grab(d)), 64'(rst_obs()));
    rst_n = 1'b1;

    foreach (tab[i]) begin
      while (k < tab[i].k) tick();
      a = grab(tab[i].d);
      chk($sformatf("vec%0d", i),
          {26'd0, a.row, a.col, a.fr, a.hs, a.vs, a.fc},
          {26'd0, 9'(tab[i].row), 10'(tab[i].col), tab[i].fr, tab[i].hs, tab[i].vs, 16'(tab[i].fc)});
    end
    while (k < 2300) tick();

    chk("hs_first_fall", 64'(hs_fall1[0]), 64'(659));
    chk("hs_period", 64'(hs_fall2[0] - hs_fall1[0]), 64'(800));
    chk("hs_low_width", 64'(hs_rise1[0] - hs_fall1[0]), 64'(96));
    chk("vs_period_small", 64'(vs_fall2[1] - vs_fall1[1]), 64'(735));
    chk("vs_low_small", 64'(vs_rise1[1] - vs_fall1[1]), 64'(70));
    chk("vs_frame_step", 64'(fc_vs2[1] - fc_vs1[1]), 64'(1));
    chk("fresh_falls_s1", 64'(fr_falls[1]), 64'(3));
    chk("fresh_falls_s3", 64'(fr_falls[2]), 64'(3));
    chk("fresh_pos_s1", 64'(fr_bad[1]), 64'(0));
    chk("fresh_pos_s3", 64'(fr_bad[2]), 64'(0));

    // Mid-frame reset at small-raster line 5, column 11
    while (!(k > 2205 && k % 735 == 186)) tick();
    #5 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) chk($sformatf("reset_async_dut%0d", d), 64'(grab(d)), 64'(rst_obs()));
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) chk($sformatf("reset_held_dut%0d", d), 64'(grab(d)), 64'(rst_obs()));
    pmode = 1; rand_col = 1'b0; fg = 12'hFFF; bg = 12'h000;
    restart();
    rst_n = 1'b1;
    while (k < 800) tick();

    chk("restart_hs_fall_f1", 64'(hs_fall1[0]), 64'(659));
    chk("restart_hs_fall_s3", 64'(hs_fall1[2]), 64'(29));
    chk("pix_count_f1", 64'(pix_cnt[0]), 64'(0));
    chk("pix_count_s1", 64'(pix_cnt[1]), 64'(1));
    chk("pix_count_s3", 64'(pix_cnt[2]), 64'(1));
    chk("pix_offset_s1", 64'(pix_off[1]), 64'(16));
    chk("pix_offset_s3", 64'(pix_off[2]), 64'(16));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
